ifm_stream_loader_3: RTL

// - Upstream feeder for the 3-channel IFM memory unit.
// - Accepts a valid/ready stream of 3-channel pixels in raster order (row-major, IFM_SIZE x IFM_SIZE).
// - Drives the memory unit's port-A write side: one address, one write enable, three data words.
// - Reports load progress and pulses done once the whole feature map has been written.

---
 rtl/ifm_stream_loader_3_if.sv | 39 +++
 rtl/ifm_stream_loader_3.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ifm_stream_loader_3_if.sv
`default_nettype none
// ============================================================================
// Module  : ifm_stream_loader_3_if
// Brief   : 3-channel pixel stream in, IFM memory port-A write side out.
// Revision: 1.0
// ============================================================================
interface ifm_stream_loader_3_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_SIZE_IFM = 8
);
  logic                        Data_In_Valid;
  logic                        Data_In_Ready;
  logic [DATA_WIDTH-1:0]       Data_In_Ch1;
  logic [DATA_WIDTH-1:0]       Data_In_Ch2;
  logic [DATA_WIDTH-1:0]       Data_In_Ch3;
  logic [ADDRESS_SIZE_IFM-1:0] Address_A;
  logic                        Enable_Write_A_Mem;
  logic                        Enable_Read_A_Mem;
  logic [DATA_WIDTH-1:0]       Data_Input_A_Mem1;
  logic [DATA_WIDTH-1:0]       Data_Input_A_Mem2;
  logic [DATA_WIDTH-1:0]       Data_Input_A_Mem3;

  // Loader side: consumes the pixel stream and drives the memory writes.
  modport slave (
    input  Data_In_Valid, Data_In_Ch1, Data_In_Ch2, Data_In_Ch3,
    output Data_In_Ready,
    output Address_A, Enable_Write_A_Mem, Enable_Read_A_Mem,
    output Data_Input_A_Mem1, Data_Input_A_Mem2, Data_Input_A_Mem3
  );

  // Upstream/memory side.
  modport master (
    output Data_In_Valid, Data_In_Ch1, Data_In_Ch2, Data_In_Ch3,
    input  Data_In_Ready,
    input  Address_A, Enable_Write_A_Mem, Enable_Read_A_Mem,
    input  Data_Input_A_Mem1, Data_Input_A_Mem2, Data_Input_A_Mem3
  );
endinterface
`default_nettype wire

// File: rtl/ifm_stream_loader_3.sv
`default_nettype none
// ============================================================================
// Module  : ifm_stream_loader_3
// Brief   : Loads one raster-order 3-channel frame into the IFM memories.
// Revision: 1.0
// ============================================================================
module ifm_stream_loader_3 #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 16,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input  wire logic                        clk,
  input  wire logic                        reset,
  input  wire logic                        start,
  ifm_stream_loader_3_if.slave             bus,
  output logic [$clog2(IFM_SIZE)-1:0]      Row_Count,
  output logic [$clog2(IFM_SIZE)-1:0]      Col_Count,
  output logic                             Busy,
  output logic                             Done
);

  localparam int CNT_W = $clog2(IFM_SIZE);
  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_PIX = ADDRESS_SIZE_IFM'(IFM_SIZE*IFM_SIZE-1);
  localparam logic [CNT_W-1:0]            LAST_COL = CNT_W'(IFM_SIZE-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                      state_q;
  logic                        ready_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        we_q;
  logic [ADDRESS_SIZE_IFM-1:0] pix_q;
  logic [ADDRESS_SIZE_IFM-1:0] addr_q;
  logic [CNT_W-1:0]            row_q;
  logic [CNT_W-1:0]            col_q;
  logic [DATA_WIDTH-1:0]       data1_q;
  logic [DATA_WIDTH-1:0]       data2_q;
  logic [DATA_WIDTH-1:0]       data3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      pix_q   <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
      data3_q <= '0;
    end else begin
      // Strobe and done are single-cycle pulses unless re-armed below.
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            pix_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        LOAD: begin
          if (bus.Data_In_Valid && ready_q) begin
            we_q    <= 1'b1;
            addr_q  <= pix_q;
            data1_q <= bus.Data_In_Ch1;
            data2_q <= bus.Data_In_Ch2;
            data3_q <= bus.Data_In_Ch3;
            pix_q   <= pix_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (pix_q == LAST_PIX) begin
              state_q <= FLUSH;
              ready_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Data_In_Ready      = ready_q;
  assign bus.Address_A          = addr_q;
  assign bus.Enable_Write_A_Mem = we_q;
  assign bus.Enable_Read_A_Mem  = 1'b0;
  assign bus.Data_Input_A_Mem1  = data1_q;
  assign bus.Data_Input_A_Mem2  = data2_q;
  assign bus.Data_Input_A_Mem3  = data3_q;
  assign Row_Count              = row_q;
  assign Col_Count              = col_q;
  assign Busy                   = busy_q;
  assign Done                   = done_q;

endmodule
`default_nettype wire
